// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Bundles the decode/ALU-facing inputs and the PC/status outputs of the
// program-counter sequencer.
//   master : decode side; drives stall, resume, op_code, inst_addr and alu,
//            and observes pc, halted, ras_full and ras_empty (plus trap)
//   slave  : the sequencer itself
// Optional macro PC_TRAP_EN adds the trap status signal.
interface pc_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              stall;
    logic              resume;
    logic [3:0]        op_code;
    logic [ADDR_W-1:0] inst_addr;
    logic [3:0]        alu;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              ras_full;
    logic              ras_empty;
`ifdef PC_TRAP_EN
    logic              trap;
`endif

    modport master (
        output stall, resume, op_code, inst_addr, alu,
`ifdef PC_TRAP_EN
        input  trap,
`endif
        input  pc, halted, ras_full, ras_empty
    );

    modport slave (
        input  stall, resume, op_code, inst_addr, alu,
`ifdef PC_TRAP_EN
        output trap,
`endif
        output pc, halted, ras_full, ras_empty
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Registered program counter with a RUN/HALT state machine, a stall input and
// a circular hardware return-address stack (RAS) for CALL/RET.
// Ports:
//   clk  : core clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   sif  : pc_sequencer_if.slave (stall, resume, op_code, inst_addr, alu in;
//          pc, halted, ras_full, ras_empty out; trap out with PC_TRAP_EN)
// Optional macro PC_TRAP_EN: RAS overflow/underflow jumps to TRAP_VEC, halts
// and pulses trap for one cycle instead of overwriting / falling through.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_RUN  | one PC update per unstalled cycle, selected by op_code
// ST_HALT | PC frozen, op_code ignored; resume (no stall) returns to RUN
module pc_sequencer #(
    parameter int                  ADDR_W    = 8,
    parameter int                  OFF_W     = 4,
    parameter int                  RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0]   RESET_PC  = '0
`ifdef PC_TRAP_EN
    ,
    parameter logic [ADDR_W-1:0]   TRAP_VEC  = '1
`endif
) (
    input logic            clk,
    input logic            rst,
    pc_sequencer_if.slave  sif
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] OP_HALT   = 4'b0000;
    localparam logic [3:0] OP_JUMP   = 4'b0101;
    localparam logic [3:0] OP_BRANCH = 4'b0110;
    localparam logic [3:0] OP_CALL   = 4'b0111;
    localparam logic [3:0] OP_RET    = 4'b1000;

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic              halted_q;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    // wr_ptr is the slot the next push lands in; the ring wraps so a push
    // while full silently replaces the oldest entry.
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  ras_cnt;
`ifdef PC_TRAP_EN
    logic              trap_q;
`endif

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_off;
    logic [PTR_W-1:0]  rd_ptr;
    logic              ras_full_w;
    logic              ras_empty_w;

    always_comb begin
        pc_inc             = pc_q + ADDR_W'(1);
        br_off             = '0;
        br_off[OFF_W-1:0]  = sif.inst_addr[OFF_W-1:0];
        rd_ptr             = wr_ptr - PTR_W'(1);
        ras_full_w         = (ras_cnt == CNT_W'(RAS_DEPTH));
        ras_empty_w        = (ras_cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            wr_ptr   <= '0;
            ras_cnt  <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
`ifdef PC_TRAP_EN
            trap_q   <= 1'b0;
`endif
        end else begin
`ifdef PC_TRAP_EN
            trap_q <= 1'b0;
`endif
            if (!sif.stall) begin
                case (state)
                    ST_RUN: begin
                        case (sif.op_code)
                            OP_HALT: begin
                                state    <= ST_HALT;
                                halted_q <= 1'b1;
                            end
                            OP_JUMP: pc_q <= sif.inst_addr;
                            OP_BRANCH: begin
                                if (sif.alu == 4'd1) pc_q <= pc_inc + br_off;
                                else                 pc_q <= pc_inc;
                            end
                            OP_CALL: begin
`ifdef PC_TRAP_EN
                                if (ras_full_w) begin
                                    pc_q     <= TRAP_VEC;
                                    state    <= ST_HALT;
                                    halted_q <= 1'b1;
                                    trap_q   <= 1'b1;
                                end else begin
                                    ras_mem[wr_ptr] <= pc_inc;
                                    wr_ptr          <= wr_ptr + PTR_W'(1);
                                    ras_cnt         <= ras_cnt + CNT_W'(1);
                                    pc_q            <= sif.inst_addr;
                                end
`else
                                ras_mem[wr_ptr] <= pc_inc;
                                wr_ptr          <= wr_ptr + PTR_W'(1);
                                if (!ras_full_w) ras_cnt <= ras_cnt + CNT_W'(1);
                                pc_q            <= sif.inst_addr;
`endif
                            end
                            OP_RET: begin
                                if (ras_empty_w) begin
`ifdef PC_TRAP_EN
                                    pc_q     <= TRAP_VEC;
                                    state    <= ST_HALT;
                                    halted_q <= 1'b1;
                                    trap_q   <= 1'b1;
`else
                                    pc_q <= pc_inc;
`endif
                                end else begin
                                    pc_q    <= ras_mem[rd_ptr];
                                    wr_ptr  <= rd_ptr;
                                    ras_cnt <= ras_cnt - CNT_W'(1);
                                end
                            end
                            default: pc_q <= pc_inc;
                        endcase
                    end
                    ST_HALT: begin
                        if (sif.resume) begin
                            state    <= ST_RUN;
                            halted_q <= 1'b0;
                            pc_q     <= pc_inc;
                        end
                    end
                    default: state <= ST_RUN;
                endcase
            end
        end
    end

    assign sif.pc        = pc_q;
    assign sif.halted    = halted_q;
    assign sif.ras_full  = ras_full_w;
    assign sif.ras_empty = ras_empty_w;
`ifdef PC_TRAP_EN
    assign sif.trap      = trap_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(8)) sif ();

    pc_sequencer #(
        .ADDR_W(8), .OFF_W(4), .RAS_DEPTH(4), .RESET_PC(8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    typedef struct {
        logic       rst;
        logic       stall;
        logic       resume;
        logic [3:0] op;
        logic [7:0] addr;
        logic [3:0] alu;
        logic [7:0] exp_pc;
        logic       exp_halted;
        logic       exp_full;
        logic       exp_empty;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic st, input logic res,
                        input logic [3:0] op, input logic [7:0] addr,
                        input logic [3:0] alu);
        rst           = r;
        sif.stall     = st;
        sif.resume    = res;
        sif.op_code   = op;
        sif.inst_addr = addr;
        sif.alu       = alu;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name, input logic [7:0] epc,
                               input logic eh, input logic ef, input logic ee);
        check({name, ".pc"},     int'(sif.pc),        int'(epc));
        check({name, ".halted"}, int'(sif.halted),    int'(eh));
        check({name, ".full"},   int'(sif.ras_full),  int'(ef));
        check({name, ".empty"},  int'(sif.ras_empty), int'(ee));
    endtask

    vec_t vecs[$];

    initial begin
        // rst stall resume op addr alu | pc halted full empty
        vecs.push_back('{1,0,0,4'h1,8'h00,4'h0, 8'h00,0,0,1});
        vecs.push_back('{0,0,0,4'h1,8'h00,4'h0, 8'h01,0,0,1});
        vecs.push_back('{0,0,0,4'h1,8'h00,4'h0, 8'h02,0,0,1});
        vecs.push_back('{0,0,0,4'h1,8'h00,4'h0, 8'h03,0,0,1});
        vecs.push_back('{0,0,0,4'h5,8'h05,4'h0, 8'h05,0,0,1});
        vecs.push_back('{0,0,0,4'h6,8'h03,4'h1, 8'h09,0,0,1});
        vecs.push_back('{0,0,0,4'h5,8'h05,4'h0, 8'h05,0,0,1});
        vecs.push_back('{0,0,0,4'h6,8'h03,4'h0, 8'h06,0,0,1});
        vecs.push_back('{0,0,0,4'h5,8'h05,4'h0, 8'h05,0,0,1});
        vecs.push_back('{0,0,0,4'h6,8'hF3,4'h1, 8'h09,0,0,1});
        vecs.push_back('{0,0,0,4'h5,8'h04,4'h0, 8'h04,0,0,1});
        vecs.push_back('{0,0,0,4'h7,8'h20,4'h0, 8'h20,0,0,0});
        vecs.push_back('{0,0,0,4'h8,8'h00,4'h0, 8'h05,0,0,1});
        vecs.push_back('{0,1,0,4'h5,8'h40,4'h0, 8'h05,0,0,1});
        vecs.push_back('{0,0,0,4'h5,8'h07,4'h0, 8'h07,0,0,1});
        vecs.push_back('{0,0,0,4'h0,8'h00,4'h0, 8'h07,1,0,1});
        vecs.push_back('{0,0,0,4'h1,8'h00,4'h0, 8'h07,1,0,1});
        vecs.push_back('{0,1,1,4'h1,8'h00,4'h0, 8'h07,1,0,1});
        vecs.push_back('{0,0,1,4'h1,8'h00,4'h0, 8'h08,0,0,1});
        vecs.push_back('{0,0,0,4'h5,8'hFF,4'h0, 8'hFF,0,0,1});
        vecs.push_back('{0,0,0,4'h1,8'h00,4'h0, 8'h00,0,0,1});
        vecs.push_back('{0,0,0,4'h7,8'h10,4'h0, 8'h10,0,0,0});
        vecs.push_back('{0,0,0,4'h7,8'h30,4'h0, 8'h30,0,0,0});
        vecs.push_back('{0,0,0,4'h0,8'h00,4'h0, 8'h30,1,0,0});
        vecs.push_back('{1,0,0,4'h1,8'h00,4'h0, 8'h00,0,0,1});
        vecs.push_back('{0,0,0,4'h6,8'h0F,4'h2, 8'h01,0,0,1});

        step(1, 0, 0, 4'h1, 8'h00, 4'h0);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].stall, vecs[i].resume, vecs[i].op,
                 vecs[i].addr, vecs[i].alu);
            check_state($sformatf("vec%0d", i), vecs[i].exp_pc,
                        vecs[i].exp_halted, vecs[i].exp_full, vecs[i].exp_empty);
`ifdef PC_TRAP_EN
            check($sformatf("vec%0d.trap", i), int'(sif.trap), 0);
`endif
        end

        // Nested calls past the stack depth, then unwind.
        step(1, 0, 0, 4'h1, 8'h00, 4'h0);
        step(0, 0, 0, 4'h7, 8'h10, 4'h0);
        step(0, 0, 0, 4'h7, 8'h20, 4'h0);
        step(0, 0, 0, 4'h7, 8'h30, 4'h0);
        step(0, 0, 0, 4'h7, 8'h40, 4'h0);
        check_state("call4", 8'h40, 0, 1, 0);
        step(0, 0, 0, 4'h7, 8'h50, 4'h0);
`ifdef PC_TRAP_EN
        check_state("call5", 8'hFF, 1, 1, 0);
        check("call5.trap", int'(sif.trap), 1);
        step(0, 0, 0, 4'h1, 8'h00, 4'h0);
        check("trap_pulse", int'(sif.trap), 0);
        check_state("trap_hold", 8'hFF, 1, 1, 0);
        step(0, 0, 1, 4'h1, 8'h00, 4'h0);
        check_state("trap_resume", 8'h00, 0, 1, 0);
        step(0, 0, 0, 4'h8, 8'h00, 4'h0);
        check_state("ret1", 8'h31, 0, 0, 0);
        step(0, 0, 0, 4'h8, 8'h00, 4'h0);
        check_state("ret2", 8'h21, 0, 0, 0);
        step(0, 0, 0, 4'h8, 8'h00, 4'h0);
        check_state("ret3", 8'h11, 0, 0, 0);
        step(0, 0, 0, 4'h8, 8'h00, 4'h0);
        check_state("ret4", 8'h01, 0, 0, 1);
        step(0, 0, 0, 4'h8, 8'h00, 4'h0);
        check_state("ret_empty", 8'hFF, 1, 0, 1);
        check("ret_empty.trap", int'(sif.trap), 1);
`else
        check_state("call5", 8'h50, 0, 1, 0);
        step(0, 0, 0, 4'h8, 8'h00, 4'h0);
        check_state("ret1", 8'h41, 0, 0, 0);
        step(0, 0, 0, 4'h8, 8'h00, 4'h0);
        check_state("ret2", 8'h31, 0, 0, 0);
        step(0, 0, 0, 4'h8, 8'h00, 4'h0);
        check_state("ret3", 8'h21, 0, 0, 0);
        step(0, 0, 0, 4'h8, 8'h00, 4'h0);
        check_state("ret4", 8'h11, 0, 0, 1);
        step(0, 0, 0, 4'h8, 8'h00, 4'h0);
        check_state("ret_empty", 8'h12, 0, 0, 1);
`endif

        // Stall holds a pending CALL off the stack entirely.
        step(1, 0, 0, 4'h1, 8'h00, 4'h0);
        step(0, 1, 0, 4'h7, 8'h44, 4'h0);
        check_state("stall_call", 8'h00, 0, 0, 1);
        step(0, 0, 0, 4'h7, 8'h44, 4'h0);
        check_state("call_after_stall", 8'h44, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
